// File: rtl/mips_pkg.sv
// mips_pkg: shared types and defaults for the instruction-fetch stage.
//   fetch_state_t    : fetch FSM encoding (REQ, READY, ERROR)
//   RESET_PC_DEFAULT : address fetched first after reset
//   TIMEOUT_DEFAULT  : REQ cycles without ack before a fetch error
package mips_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_READY = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          TIMEOUT_DEFAULT  = 8;

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer: wait counter for an outstanding instruction request.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force the count back to zero (wins over enable)
//   enable    : count one more waiting cycle
//   expired   : combinational, high in the enabled cycle whose count is
//               TIMEOUT-1, i.e. the last waiting cycle before a timeout
// The count wraps to zero on the expiring cycle so a retry starts fresh.
module fetch_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expired = enable && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      if (expired) cnt <= '0;
      else         cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage holding PC, instruction register and the
// fetch FSM (REQ -> READY on ack, REQ -> ERROR on timeout, ERROR -> REQ retry).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   npc_in, pc_we, stall: next-PC value, load request, hazard stall
//   imem_req, imem_addr : instruction-memory read request and word address
//   imem_ack, imem_rdata: memory response and instruction word
//   pc_out, pc_plus4    : current PC and PC+4 (combinational, wraps)
//   instr, instr_valid  : instruction register and its valid flag
//   misalign            : pulse the cycle after loading an npc_in with [1:0]!=0
//   fetch_err           : pulse during the single ERROR cycle
//   state_dbg           : current FSM state for observation
// Memory handshake: imem_req stays high for every REQ cycle until a cycle in
// which imem_ack is high; that edge transfers imem_rdata. imem_ack seen in any
// other state is ignored, and no new request is accepted until READY.
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  npc_in,
  input  logic         pc_we,
  input  logic         stall,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  pc_out,
  output logic [31:0]  pc_plus4,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         misalign,
  output logic         fetch_err,
  output fetch_state_t state_dbg
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_q, instr_q;
  logic         misalign_q;
  logic         timer_expired;
  logic         load_ir, load_pc;

  // Ack takes priority over a same-cycle timeout.
  assign load_ir = (state == ST_REQ) && imem_ack;
  assign load_pc = (state == ST_READY) && pc_we && !stall;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != ST_REQ) || imem_ack),
    .enable (state == ST_REQ),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      if (load_ir) instr_q <= imem_rdata;
      if (load_pc) pc_q    <= {npc_in[31:2], 2'b00};
      misalign_q <= load_pc && (npc_in[1:0] != 2'b00);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ: begin
        if (imem_ack)           state_nxt = ST_READY;
        else if (timer_expired) state_nxt = ST_ERROR;
      end
      ST_READY: begin
        if (pc_we && !stall)    state_nxt = ST_REQ;
      end
      ST_ERROR:                 state_nxt = ST_REQ;
      default:                  state_nxt = ST_REQ;
    endcase
  end

  assign imem_req    = (state == ST_REQ);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = (state == ST_READY);
  assign misalign    = misalign_q;
  assign fetch_err   = (state == ST_ERROR);
  assign state_dbg   = state;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with an instruction scoreboard.
module tb_ifetch;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  npc_in;
  logic         pc_we, stall;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic [31:0]  pc_out, pc_plus4, instr;
  logic         instr_valid, misalign, fetch_err;
  fetch_state_t state_dbg;

  always #5 clk = ~clk;

  ifetch dut (
    .clk        (clk),
    .rst        (rst),
    .npc_in     (npc_in),
    .pc_we      (pc_we),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .misalign   (misalign),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive an ack with rdata for one edge and record the word as expected.
  task automatic ack_word(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    exp_q.push_back(w);
    tick();
    imem_ack   = 1'b0;
  endtask

  // Pop the oldest expected word once instr_valid is seen (bounded wait).
  task automatic expect_instr(input string tag);
    logic [31:0] e;
    int guard;
    guard = 0;
    while (!instr_valid && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_instr"}, instr, e);
    end
  endtask

  task automatic load_pc(input logic [31:0] npc);
    pc_we  = 1'b1;
    npc_in = npc;
    tick();
    pc_we  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] npc, w;
    int dly;

    rst = 1'b1; npc_in = 32'h0; pc_we = 1'b0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #1;
    tick();
    // Ack during reset must be dropped.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rst_state", 32'(state_dbg), 32'(ST_REQ));
    chk("rst_pc", pc_out, 32'h3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_ferr", {31'b0, fetch_err}, 32'd0);

    // First cycle after release: request at RESET_PC.
    rst = 1'b0; imem_ack = 1'b0;
    chk("rel_req", {31'b0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h3000);

    // Ack in the first REQ cycle.
    ack_word(32'h2408_0001);
    expect_instr("first");
    chk("first_pc", pc_out, 32'h3000);
    chk("first_pc4", pc_plus4, 32'h3004);
    chk("first_req", {31'b0, imem_req}, 32'd0);

    // Ack while READY is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
    tick();
    imem_ack = 1'b0;
    chk("ready_ack_instr", instr, 32'h2408_0001);
    chk("ready_ack_valid", {31'b0, instr_valid}, 32'd1);

    // Stall blocks the load for 5 cycles.
    stall = 1'b1; pc_we = 1'b1; npc_in = 32'h3040;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc_out, 32'h3000);
      chk("stall_instr", instr, 32'h2408_0001);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0; pc_we = 1'b0;

    // Load 0x3010, ack two cycles later; pc_we during REQ ignored.
    load_pc(32'h3010);
    chk("ld_req", {31'b0, imem_req}, 32'd1);
    chk("ld_addr", imem_addr, 32'h3010);
    chk("ld_misalign", {31'b0, misalign}, 32'd0);
    chk("ld_valid", {31'b0, instr_valid}, 32'd0);
    pc_we = 1'b1; npc_in = 32'h4000;
    tick();
    pc_we = 1'b0;
    chk("req_we_ignored", pc_out, 32'h3010);
    ack_word(32'h8C09_0004);
    expect_instr("second");
    chk("second_pc", pc_out, 32'h3010);

    // Timeout: 8 REQ cycles without ack -> one ERROR cycle -> retry.
    load_pc(32'h3020);
    for (int i = 0; i < 8; i++) begin
      chk("to_req", {31'b0, imem_req}, 32'd1);
      chk("to_ferr_lo", {31'b0, fetch_err}, 32'd0);
      tick();
    end
    chk("to_ferr", {31'b0, fetch_err}, 32'd1);
    chk("to_err_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("retry_ferr", {31'b0, fetch_err}, 32'd0);
    chk("retry_req", {31'b0, imem_req}, 32'd1);
    chk("retry_addr", imem_addr, 32'h3020);

    // Ack coinciding with the timeout cycle resolves to READY.
    for (int i = 0; i < 7; i++) tick();
    ack_word(32'h0000_0020);
    chk("tie_ferr", {31'b0, fetch_err}, 32'd0);
    expect_instr("tie");

    // pc_plus4 wraps.
    load_pc(32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    ack_word(32'h1234_5678);
    expect_instr("wrap");

    // Misaligned load, then ack and reset in the same cycle.
    load_pc(32'h3013);
    chk("mis_pc", pc_out, 32'h3010);
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    tick();
    chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; rst = 1'b1;
    tick();
    imem_ack = 1'b0; rst = 1'b0;
    chk("ackrst_state", 32'(state_dbg), 32'(ST_REQ));
    chk("ackrst_pc", pc_out, 32'h3000);
    chk("ackrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("ackrst_instr", instr, 32'h0);
    ack_word(32'h2408_0002);
    expect_instr("post_rst");

    // Random fetches with random ack delays (below the timeout).
    for (int k = 0; k < 6; k++) begin
      npc = 32'h5000 + 32'($urandom_range(0, 1023));
      load_pc(npc);
      chk("rnd_pc", pc_out, {npc[31:2], 2'b00});
      chk("rnd_mis", {31'b0, misalign}, {31'b0, npc[1:0] != 2'b00});
      dly = $urandom_range(0, 5);
      repeat (dly) tick();
      w = $urandom;
      ack_word(w);
      expect_instr("rnd");
    end

    chk("q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the address fetched first after reset.
REQ-002 Parameter TIMEOUT, default 8, SHALL be the number of REQ cycles without ack before a fetch error.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 npc_in  input  32  next-PC value from the next-PC logic.
REQ-006 pc_we  input  1  request to load npc_in and fetch the next instruction.
REQ-007 stall  input  1  hazard stall; blocks the pc_we load.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  32  word address of the request (equals pc_out).
REQ-010 imem_ack  input  1  memory has returned imem_rdata this cycle.
REQ-011 imem_rdata  input  32  instruction word from memory.
REQ-012 pc_out  output  32  address of the instruction held in instr.
REQ-013 pc_plus4  output  32  pc_out+4; fed to the next-PC logic as its pc input.
REQ-014 instr  output  32  latched instruction register.
REQ-015 instr_valid  output  1  instr holds the word for pc_out.
REQ-016 misalign  output  1  one-cycle pulse: the loaded npc_in had nonzero bits [1:0].
REQ-017 fetch_err  output  1  one-cycle pulse: the request timed out.

Function
REQ-018 The block SHALL implement three states: REQ, READY and ERROR.
REQ-019 REQ: imem_req=1, imem_addr=pc_out, instr_valid=0; the wait counter SHALL increment each cycle.
REQ-020 REQ with imem_ack=1 at an edge: instr<=imem_rdata, wait counter<=0, next state READY.
REQ-021 REQ with counter==TIMEOUT-1 and no ack: next state ERROR, counter<=0.
REQ-022 A same-cycle ack and timeout SHALL resolve to ack (READY).
REQ-023 ERROR: lasts exactly one cycle with fetch_err=1 and imem_req=0, then returns to REQ with an unchanged pc_out (retry).
REQ-024 READY: instr_valid=1 and imem_req=0.
REQ-025 READY with pc_we=1 and stall=0: pc_out<={npc_in[31:2],2'b00}, next state REQ.
REQ-026 READY with stall=1: pc_out, instr and state SHALL hold regardless of pc_we.
REQ-027 pc_we in REQ or ERROR SHALL be ignored; no queuing.
REQ-028 misalign SHALL pulse the cycle after a load per REQ-025 whose npc_in[1:0]!=0.
REQ-029 pc_plus4 SHALL be combinational pc_out+32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-030 imem_ack outside REQ SHALL be ignored.
REQ-031 Minimum fetch latency: one cycle in REQ; instr_valid rises the cycle after the ack edge.

Reset
REQ-032 rst=1 at an edge SHALL set state=REQ, pc_out=RESET_PC, instr=32'h0, wait counter=0, misalign=0 and fetch_err=0, overriding all other inputs.
REQ-033 Reset during an outstanding request SHALL abandon it; an ack arriving during reset SHALL be dropped.
REQ-034 In the first cycle after reset is released: imem_req=1 and imem_addr=RESET_PC.

Structure
REQ-035 A shared package mips_pkg SHALL hold the state enum, RESET_PC default and TIMEOUT default.
REQ-036 The wait counter SHALL be a sub-module fetch_timer (inputs: clear, enable; output: expired); the FSM, PC and IR stay in ifetch.

Verification
REQ-037 Reset release, ack in the first REQ cycle with rdata=32'h2408_0001 -> next cycle instr_valid=1, instr=32'h2408_0001, pc_out=32'h3000, pc_plus4=32'h3004.
REQ-038 READY, pc_we=1, stall=0, npc_in=32'h3010 -> next cycle imem_req=1 and imem_addr=32'h3010; ack two cycles later -> instr_valid.
REQ-039 READY, stall=1 with pc_we=1 for 5 cycles -> pc_out and instr unchanged and imem_req=0 throughout.
REQ-040 No ack for 8 REQ cycles -> fetch_err pulse for one cycle, then REQ resumes with the same imem_addr.
REQ-041 npc_in=32'h3013 loaded -> pc_out=32'h3010 and a misalign pulse; then ack and rst asserted in the same cycle -> state REQ, pc_out=32'h3000, instr_valid=0.
